alu_request_arbiter: RTL and testbench

//  Shares one Arithmetic_logic_unit instance among NREQ requesters.

---
 rtl/alu_request_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_alu_request_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_arbiter.sv
// ---------------------------------------------------------------------------
// alu_request_arbiter
//   Shares one 8-bit ALU among NREQ requesters. A round-robin arbiter grants
//   one request per transaction and latches its operands. The ALU then runs
//   from those registers. The result is returned, tagged with the requester
//   id, on a single registered valid/ready response channel. Each transaction
//   walks IDLE -> EXEC -> RESP, so at most one operation is in flight.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   req_valid  per-requester valid
//   req_ready  one-hot grant, combinational, only ever set in IDLE
//   req_a/b    per-requester operands, 8 bits each, slice i = [8i+7:8i]
//   req_op     per-requester ALU select, 4 bits each, slice i = [4i+3:4i]
//   rsp_valid  result available; rsp_* are held stable until rsp_ready
//   rsp_ready  consumer accepts the result
//   rsp_id     owning requester index
//   rsp_data   result byte
//   rsp_carry  adder carry, only for op 4'b0000
//   rsp_err    divide-by-zero flag
//   busy       transaction in progress (state != IDLE)
//   op_count   completed responses, saturating
//
// ALU op map
//   0 add  1 sub  2 mul (low byte)  3 div  4 shl  5 shr  6 rol  7 ror
//   8 and  9 or   A xor  B nor  C nand  D xnor  E a>b  F a==b
// ---------------------------------------------------------------------------
module alu_request_arbiter #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    input  logic [4*NREQ-1:0]   req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [7:0]          rsp_data,
    output logic                rsp_carry,
    output logic                rsp_err,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_grant_id;
    logic              w_grant_found;
    logic [ID_W-1:0]   w_idx;

    logic [7:0]        r_a;
    logic [7:0]        r_b;
    logic [3:0]        r_op;
    logic [ID_W-1:0]   r_id;

    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [7:0]        r_rsp_data;
    logic              r_rsp_carry;
    logic              r_rsp_err;
    logic [CNT_W-1:0]  r_op_count;

    logic [8:0]        w_sum;
    logic [15:0]       w_prod;
    logic [7:0]        w_alu_data;
    logic              w_alu_carry;
    logic              w_alu_err;

    // Round-robin search starting just after the last grant, wrapping mod NREQ.
    // NOTE: every signal written in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NREQ);
            if (!w_grant_found && req_valid[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && w_grant_found) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_grant_found) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ALU driven only from the latched operands. The divider branch is masked
    // when b==0 so an undefined quotient never reaches the response.
    always_comb begin
        w_sum       = {1'b0, r_a} + {1'b0, r_b};
        w_prod      = 16'(r_a) * 16'(r_b);
        w_alu_data  = '0;
        w_alu_carry = 1'b0;
        w_alu_err   = 1'b0;
        unique case (r_op)
            4'h0: begin
                w_alu_data  = w_sum[7:0];
                w_alu_carry = w_sum[8];
            end
            4'h1: w_alu_data = r_a - r_b;
            4'h2: w_alu_data = w_prod[7:0];
            4'h3: begin
                if (r_b == 8'd0) begin
                    w_alu_data = 8'hFF;
                    w_alu_err  = 1'b1;
                end else begin
                    w_alu_data = r_a / r_b;
                end
            end
            4'h4: w_alu_data = {r_a[6:0], 1'b0};
            4'h5: w_alu_data = {1'b0, r_a[7:1]};
            4'h6: w_alu_data = {r_a[6:0], r_a[7]};
            4'h7: w_alu_data = {r_a[0], r_a[7:1]};
            4'h8: w_alu_data = r_a & r_b;
            4'h9: w_alu_data = r_a | r_b;
            4'hA: w_alu_data = r_a ^ r_b;
            4'hB: w_alu_data = ~(r_a | r_b);
            4'hC: w_alu_data = ~(r_a & r_b);
            4'hD: w_alu_data = ~(r_a ^ r_b);
            4'hE: w_alu_data = (r_a > r_b) ? 8'd1 : 8'd0;
            4'hF: w_alu_data = (r_a == r_b) ? 8'd1 : 8'd0;
            default: w_alu_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= ID_W'(NREQ - 1);
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                IDLE: if (w_grant_found) r_ptr <= w_grant_id;
                EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_data  <= w_alu_data;
                    r_rsp_carry <= w_alu_carry;
                    r_rsp_err   <= w_alu_err;
                end
                RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    if (r_op_count != '1) r_op_count <= r_op_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the operand/id capture registers carry no reset; they are always
    // written at grant before EXEC reads them, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_grant_found) begin
            r_a  <= req_a[8*w_grant_id +: 8];
            r_b  <= req_b[8*w_grant_id +: 8];
            r_op <= req_op[4*w_grant_id +: 4];
            r_id <= w_grant_id;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_err   = r_rsp_err;
    assign op_count  = r_op_count;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_request_arbiter
//   Self-checking bench. A table of single transactions (one per requester
//   slot) is applied in a loop. Expected responses are pushed to a scoreboard
//   queue at grant time and popped when the response handshakes. Hand-written
//   sequences cover round-robin order, back-pressure and mid-RESP reset.
// ---------------------------------------------------------------------------
module tb_alu_request_arbiter;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [4*NREQ-1:0]   req_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [7:0]          rsp_data;
    logic                rsp_carry;
    logic                rsp_err;
    logic                busy;
    logic [CNT_W-1:0]    op_count;

    always #5 clk = ~clk;

    alu_request_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .op_count  (op_count)
    );

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] data;
        logic       carry;
        logic       err;
    } vec_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [7:0]      data;
        logic            carry;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        req_a[8*v.id +: 8]  = v.a;
        req_b[8*v.id +: 8]  = v.b;
        req_op[4*v.id +: 4] = v.op;
        req_valid[v.id]     = 1'b1;
        #1;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.id    = ID_W'(v.id);
        e.data  = v.data;
        e.carry = v.carry;
        e.err   = v.err;
        sb.push_back(e);
    endtask

    task automatic wait_grant(output int g);
        bit ok;
        ok = 1'b0;
        g  = -1;
        for (int n = 0; n < 30; n++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        end else begin
            total++;
            bad++;
            $display("FAIL grant_timeout: got no req_ready expected a grant");
        end
    endtask

    // Waits (bounded) for rsp_valid, compares against the scoreboard head,
    // then takes the handshake edge (rsp_ready must already be 1).
    task automatic collect(input string name);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_rsp_timeout: got no rsp_valid expected a response", name);
        end else if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_unexpected: got id %0d expected no response", name, rsp_id);
            tick();
        end else begin
            e = sb.pop_front();
            check({name, "_id"},    32'(rsp_id),    32'(e.id));
            check({name, "_data"},  32'(rsp_data),  32'(e.data));
            check({name, "_carry"}, 32'(rsp_carry), 32'(e.carry));
            check({name, "_err"},   32'(rsp_err),   32'(e.err));
            tick();
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int g;
        drive(v);
        wait_grant(g);
        check({name, "_ready"}, 32'(req_ready), 32'(1 << v.id));
        push_exp(v);
        tick();
        req_valid[v.id] = 1'b0;
        check({name, "_exec_not_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        check({name, "_latency_valid"}, 32'(rsp_valid), 32'd1);
        collect(name);
    endtask

    vec_t vecs[20];
    vec_t rr[4];
    int   rr_order[5];
    vec_t v;
    int   g;

    initial begin
        vecs[0]  = '{0, 8'd200, 8'd100, 4'h0, 8'd44,  1'b1, 1'b0};
        vecs[1]  = '{2, 8'd9,   8'd0,   4'h3, 8'hFF,  1'b0, 1'b1};
        vecs[2]  = '{2, 8'd9,   8'd2,   4'h3, 8'd4,   1'b0, 1'b0};
        vecs[3]  = '{0, 8'd5,   8'd3,   4'hE, 8'd1,   1'b0, 1'b0};
        vecs[4]  = '{0, 8'd5,   8'd3,   4'hF, 8'd0,   1'b0, 1'b0};
        vecs[5]  = '{1, 8'd3,   8'd5,   4'h1, 8'hFE,  1'b0, 1'b0};
        vecs[6]  = '{3, 8'd12,  8'd11,  4'h2, 8'h84,  1'b0, 1'b0};
        vecs[7]  = '{1, 8'd20,  8'd20,  4'h2, 8'h90,  1'b0, 1'b0};
        vecs[8]  = '{3, 8'h81,  8'h00,  4'h4, 8'h02,  1'b0, 1'b0};
        vecs[9]  = '{2, 8'h81,  8'h00,  4'h5, 8'h40,  1'b0, 1'b0};
        vecs[10] = '{0, 8'h81,  8'h00,  4'h6, 8'h03,  1'b0, 1'b0};
        vecs[11] = '{1, 8'h81,  8'h00,  4'h7, 8'hC0,  1'b0, 1'b0};
        vecs[12] = '{3, 8'hF0,  8'h3C,  4'h8, 8'h30,  1'b0, 1'b0};
        vecs[13] = '{3, 8'hF0,  8'h3C,  4'h9, 8'hFC,  1'b0, 1'b0};
        vecs[14] = '{2, 8'hF0,  8'h3C,  4'hA, 8'hCC,  1'b0, 1'b0};
        vecs[15] = '{2, 8'hF0,  8'h3C,  4'hB, 8'h03,  1'b0, 1'b0};
        vecs[16] = '{1, 8'hF0,  8'h3C,  4'hC, 8'hCF,  1'b0, 1'b0};
        vecs[17] = '{0, 8'hF0,  8'h3C,  4'hD, 8'h33,  1'b0, 1'b0};
        vecs[18] = '{2, 8'd255, 8'd1,   4'h0, 8'd0,   1'b1, 1'b0};
        vecs[19] = '{1, 8'd1,   8'd2,   4'h0, 8'd3,   1'b0, 1'b0};

        rr[0] = '{0, 8'd10, 8'd1, 4'h0, 8'd11, 1'b0, 1'b0};
        rr[1] = '{1, 8'd10, 8'd1, 4'h1, 8'd9,  1'b0, 1'b0};
        rr[2] = '{2, 8'd10, 8'd3, 4'h2, 8'd30, 1'b0, 1'b0};
        rr[3] = '{3, 8'd10, 8'd3, 4'h3, 8'd3,  1'b0, 1'b0};
        rr_order = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id",    32'(rsp_id),    32'd0);
        check("reset_rsp_data",  32'(rsp_data),  32'd0);
        check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
        check("reset_rsp_err",   32'(rsp_err),   32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_op_count",  32'(op_count),  32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_no_req_busy", 32'(busy), 32'd0);

        // Table-driven single transactions
        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        check("table_op_count", 32'(op_count), 32'd20);

        // Round-robin with all four requesters holding valid
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) drive(rr[i]);
        for (int n = 0; n < 5; n++) begin
            wait_grant(g);
            check($sformatf("rr_grant%0d", n), 32'(g), 32'(rr_order[n]));
            if (g >= 0) push_exp(rr[g]);
            tick();
            if (n == 4) req_valid = '0;
            collect($sformatf("rr%0d", n));
        end
        check("rr_op_count", 32'(op_count), 32'd5);

        // Back-pressure: response held stable for 5 cycles
        rsp_ready = 1'b0;
        drive(vecs[5]);
        wait_grant(g);
        check("bp_grant", 32'(g), 32'd1);
        push_exp(vecs[5]);
        tick();
        req_valid[1] = 1'b0;
        tick();
        drive(vecs[19]);
        v = vecs[19];
        v.id = 0;
        drive(v);
        for (int n = 0; n < 5; n++) begin
            check($sformatf("bp_valid%0d", n), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_data%0d", n),  32'(rsp_data),  32'hFE);
            check($sformatf("bp_carry%0d", n), 32'(rsp_carry), 32'd0);
            check($sformatf("bp_ready%0d", n), 32'(req_ready), 32'd0);
            check($sformatf("bp_busy%0d", n),  32'(busy),      32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid[1] = 1'b0;
        collect("bp");
        check("bp_after_busy",  32'(busy),      32'd0);
        check("bp_after_valid", 32'(rsp_valid), 32'd0);
        check("bp_after_ready", 32'(req_ready), 32'b0001);
        check("bp_op_count",    32'(op_count),  32'd6);
        push_exp(v);
        tick();
        req_valid = '0;
        collect("bp_next");
        check("bp_next_op_count", 32'(op_count), 32'd7);

        // Reset while in RESP: transaction discarded, pointer back to NREQ-1
        rsp_ready = 1'b0;
        v = '{1, 8'd10, 8'd20, 4'h0, 8'd30, 1'b0, 1'b0};
        drive(v);
        wait_grant(g);
        check("rst_pre_grant", 32'(g), 32'd1);
        push_exp(v);
        tick();
        req_valid[1] = 1'b0;
        drive('{3, 8'd7, 8'd7, 4'hF, 8'd1, 1'b0, 1'b0});
        tick();
        tick();
        check("rst_pre_resp", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        req_valid[1] = 1'b1;
        tick();
        rst_n = 1'b1;
        sb.delete();
        check("rst_mid_valid",    32'(rsp_valid), 32'd0);
        check("rst_mid_op_count", 32'(op_count),  32'd0);
        check("rst_mid_busy",     32'(busy),      32'd0);
        check("rst_mid_ready",    32'(req_ready), 32'b0010);
        rsp_ready = 1'b1;
        push_exp(v);
        tick();
        req_valid[1] = 1'b0;
        collect("rst_req1");
        wait_grant(g);
        check("rst_next_grant", 32'(g), 32'd3);
        push_exp('{3, 8'd7, 8'd7, 4'hF, 8'd1, 1'b0, 1'b0});
        tick();
        req_valid = '0;
        collect("rst_req3");
        check("rst_op_count", 32'(op_count), 32'd2);
        tick();
        check("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
